// File: rtl/net_sequencer.sv
// Batch sequencer: buffers input samples, runs them one at a time through an
// external network and hands each captured result to a downstream consumer.
module net_sequencer #(
    parameter int unsigned I       = 2,
    parameter int unsigned O       = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [32*I-1:0]   load_data,
    output logic              load_ready,
    input  logic              go,
    output logic              net_start,
    output logic [32*I-1:0]   net_x,
    input  logic [32*O-1:0]   net_y,
    input  logic              net_done,
    output logic              res_valid,
    output logic [32*O-1:0]   res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              batch_done,
    output logic              err,
    output logic [7:0]        count
);

    localparam int unsigned XW = 32 * I;
    localparam int unsigned YW = 32 * O;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NB = 1 << PW;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0]    DEPTH_C = 8'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_buf [NB];
    logic [7:0]      r_count;
    logic [PW-1:0]   r_wr_ptr;
    logic [7:0]      r_rd_ptr;
    logic [TW-1:0]   r_timer;
    logic            r_done_q;
    logic            r_net_start;
    logic [XW-1:0]   r_net_x;
    logic            r_res_valid;
    logic [YW-1:0]   r_res_data;
    logic            r_busy;
    logic            r_batch_done;
    logic            r_err;

    logic            w_load_ready;
    logic            w_load_fire;
    logic            w_done_edge;
    logic            w_more;
    logic [XW-1:0]   w_first_x;
    logic [XW-1:0]   w_next_x;

    assign w_load_ready = (r_state == ST_IDLE) && (r_count < DEPTH_C);
    assign w_load_fire  = load_valid & w_load_ready;
    assign w_done_edge  = net_done & ~r_done_q;
    assign w_more       = ({1'b0, r_rd_ptr} + 9'd1) < {1'b0, r_count};
    // An empty buffer means the first sample is the one being loaded right now
    assign w_first_x    = (r_count == 8'd0) ? load_data : r_buf[0];
    assign w_next_x     = r_buf[PW'(r_rd_ptr + 8'd1)];

    // Sample storage; contents are meaningless once count is cleared
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_buf[r_wr_ptr] <= load_data;
        end
    end

    // Sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= 8'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= 8'd0;
            r_timer      <= '0;
            r_done_q     <= 1'b0;
            r_net_start  <= 1'b0;
            r_net_x      <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_busy       <= 1'b0;
            r_batch_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done_q     <= net_done;
            r_net_start  <= 1'b0;
            r_batch_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load_fire) begin
                        r_count  <= r_count + 8'd1;
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                    end
                    if (go && ((r_count != 8'd0) || w_load_fire)) begin
                        r_state     <= ST_LAUNCH;
                        r_busy      <= 1'b1;
                        r_rd_ptr    <= 8'd0;
                        r_err       <= 1'b0;
                        r_net_start <= 1'b1;
                        r_net_x     <= w_first_x;
                    end
                end
                ST_LAUNCH: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done_edge) begin
                        r_res_data  <= net_y;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_EMIT;
                    end else if (r_timer == T_LAST) begin
                        r_err        <= 1'b1;
                        r_count      <= 8'd0;
                        r_wr_ptr     <= '0;
                        r_rd_ptr     <= 8'd0;
                        r_busy       <= 1'b0;
                        r_batch_done <= 1'b1;
                        r_net_x      <= '0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_more) begin
                            r_rd_ptr    <= r_rd_ptr + 8'd1;
                            r_net_start <= 1'b1;
                            r_net_x     <= w_next_x;
                            r_state     <= ST_LAUNCH;
                        end else begin
                            r_count      <= 8'd0;
                            r_wr_ptr     <= '0;
                            r_rd_ptr     <= 8'd0;
                            r_busy       <= 1'b0;
                            r_batch_done <= 1'b1;
                            r_net_x      <= '0;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign load_ready = w_load_ready;
    assign net_start  = r_net_start;
    assign net_x      = r_net_x;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign busy       = r_busy;
    assign batch_done = r_batch_done;
    assign err        = r_err;
    assign count      = r_count;

endmodule

// File: tb/tb_net_sequencer.sv
// Directed bench for net_sequencer: one default instance plus a short-timeout
// instance for the timeout and go/load-same-cycle cases.
module tb_net_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid, go, net_done, res_ready;
    logic [63:0] load_data;
    logic [31:0] net_y;
    logic        load_ready, net_start, res_valid, busy, batch_done, err;
    logic [63:0] net_x;
    logic [31:0] res_data;
    logic [7:0]  count;

    logic        t_load_valid, t_go, t_net_done;
    logic [63:0] t_load_data;
    logic        t_load_ready, t_net_start, t_res_valid, t_busy, t_batch_done, t_err;
    logic [63:0] t_net_x;
    logic [31:0] t_res_data;
    logic [7:0]  t_count;

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int s0;

    logic [63:0] d_tab [4] = '{64'h00000001_3F800000, 64'h00000002_40000000,
                               64'h00000003_40400000, 64'h00000004_40800000};
    logic [31:0] y_tab [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    always #5 clk = ~clk;

    always @(posedge clk) if (net_start) starts++;

    net_sequencer #(.I(2), .O(1), .DEPTH(4), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .go(go), .net_start(net_start), .net_x(net_x),
        .net_y(net_y), .net_done(net_done), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy), .batch_done(batch_done), .err(err), .count(count)
    );

    net_sequencer #(.I(2), .O(1), .DEPTH(4), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .load_valid(t_load_valid), .load_data(t_load_data),
        .load_ready(t_load_ready), .go(t_go), .net_start(t_net_start), .net_x(t_net_x),
        .net_y(32'h0), .net_done(t_net_done), .res_valid(t_res_valid), .res_data(t_res_data),
        .res_ready(1'b1), .busy(t_busy), .batch_done(t_batch_done), .err(t_err), .count(t_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; go = 1'b0;
        net_y = '0; net_done = 1'b0; res_ready = 1'b0;
        t_load_valid = 1'b0; t_load_data = '0; t_go = 1'b0; t_net_done = 1'b0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_net_start", 64'(net_start), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_batch_done", 64'(batch_done), 64'd0);
        chk("rst_net_x", net_x, 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single sample, network answers 20 cycles after the start pulse
        load_valid = 1'b1; load_data = 64'h00000000_3F800000;
        tick();
        load_valid = 1'b0;
        chk("a_count", 64'(count), 64'd1);
        s0 = starts;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("a_start", 64'(net_start), 64'd1);
        chk("a_net_x", net_x, 64'h00000000_3F800000);
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_no_load", 64'(load_ready), 64'd0);
        tick();
        chk("a_start_pulse", 64'(net_start), 64'd0);
        repeat (19) tick();
        chk("a_no_early_res", 64'(res_valid), 64'd0);
        net_done = 1'b1; net_y = 32'h3F800000;
        tick();
        chk("a_res_valid", 64'(res_valid), 64'd1);
        chk("a_res_data", 64'(res_data), 64'h3F800000);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0; net_done = 1'b0;
        chk("a_batch_done", 64'(batch_done), 64'd1);
        chk("a_busy_end", 64'(busy), 64'd0);
        chk("a_res_drop", 64'(res_valid), 64'd0);
        chk("a_count_end", 64'(count), 64'd0);
        tick();
        chk("a_bd_pulse", 64'(batch_done), 64'd0);
        chk("a_one_start", 64'(starts - s0), 64'd1);

        // Fill to DEPTH, overflow attempt, then run four samples in order
        for (int k = 0; k < 4; k++) begin
            load_valid = 1'b1; load_data = d_tab[k];
            tick();
        end
        chk("b_full_count", 64'(count), 64'd4);
        chk("b_full_ready", 64'(load_ready), 64'd0);
        load_data = 64'hDEADBEEF_DEADBEEF;
        tick();
        load_valid = 1'b0;
        chk("b_fifth_rejected", 64'(count), 64'd4);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b_start", 64'(net_start), 64'd1);
            chk("b_net_x", net_x, d_tab[k]);
            tick();
            net_done = 1'b1; net_y = y_tab[k];
            tick();
            net_done = 1'b0;
            chk("b_res_valid", 64'(res_valid), 64'd1);
            chk("b_res_data", 64'(res_data), 64'(y_tab[k]));
            if (k == 0) begin
                net_y = 32'hFFFFFFFF;
                for (int j = 0; j < 10; j++) begin
                    tick();
                    chk("b_hold_data", 64'(res_data), 64'(y_tab[0]));
                    chk("b_hold_valid", 64'(res_valid), 64'd1);
                    chk("b_hold_no_start", 64'(net_start), 64'd0);
                end
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        chk("b_batch_done", 64'(batch_done), 64'd1);
        chk("b_count_end", 64'(count), 64'd0);
        chk("b_busy_end", 64'(busy), 64'd0);

        // net_done held high across the second sample's launch
        load_valid = 1'b1; load_data = 64'hCAFE0000_00000001;
        tick();
        load_data = 64'hCAFE0000_00000002;
        tick();
        load_valid = 1'b0; go = 1'b1;
        tick();
        go = 1'b0;
        chk("c_net_x0", net_x, 64'hCAFE0000_00000001);
        tick();
        net_done = 1'b1; net_y = 32'hAAAA0001;
        tick();
        chk("c_res0", 64'(res_data), 64'hAAAA0001);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0; net_y = 32'hAAAA0002;
        chk("c_start1", 64'(net_start), 64'd1);
        chk("c_net_x1", net_x, 64'hCAFE0000_00000002);
        tick();
        repeat (3) begin
            tick();
            chk("c_held_level", 64'(res_valid), 64'd0);
        end
        net_done = 1'b0;
        tick();
        chk("c_low", 64'(res_valid), 64'd0);
        net_done = 1'b1;
        tick();
        chk("c_res_valid1", 64'(res_valid), 64'd1);
        chk("c_res1", 64'(res_data), 64'hAAAA0002);
        net_done = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("c_batch_done", 64'(batch_done), 64'd1);

        // Timeout instance: empty go ignored, timeout, then load+go together
        t_go = 1'b1;
        tick();
        t_go = 1'b0;
        chk("t_empty_go_busy", 64'(t_busy), 64'd0);
        chk("t_empty_go_start", 64'(t_net_start), 64'd0);
        t_load_valid = 1'b1; t_load_data = 64'h12345678_9ABCDEF0;
        tick();
        t_load_valid = 1'b0; t_go = 1'b1;
        tick();
        t_go = 1'b0;
        chk("t_start", 64'(t_net_start), 64'd1);
        tick();
        for (int n = 0; n < 15; n++) begin
            tick();
            chk("t_no_early_timeout", 64'(t_batch_done), 64'd0);
        end
        tick();
        chk("t_batch_done", 64'(t_batch_done), 64'd1);
        chk("t_err", 64'(t_err), 64'd1);
        chk("t_count", 64'(t_count), 64'd0);
        chk("t_busy", 64'(t_busy), 64'd0);
        tick();
        chk("t_bd_pulse", 64'(t_batch_done), 64'd0);
        chk("t_err_sticky", 64'(t_err), 64'd1);
        t_load_valid = 1'b1; t_load_data = 64'h0BADF00D_00C0FFEE; t_go = 1'b1;
        tick();
        t_load_valid = 1'b0; t_go = 1'b0;
        chk("t_same_cycle_start", 64'(t_net_start), 64'd1);
        chk("t_same_cycle_x", t_net_x, 64'h0BADF00D_00C0FFEE);
        chk("t_same_cycle_count", 64'(t_count), 64'd1);
        chk("t_err_cleared", 64'(t_err), 64'd0);

        // Reset pulse mid-WAIT aborts the batch
        load_valid = 1'b1; load_data = 64'h55555555_66666666;
        tick();
        load_valid = 1'b0; go = 1'b1;
        tick();
        go = 1'b0;
        tick(); tick();
        chk("r_busy_pre", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_async_busy", 64'(busy), 64'd0);
        chk("r_async_net_x", net_x, 64'd0);
        chk("r_async_count", 64'(count), 64'd0);
        chk("r_async_start", 64'(net_start), 64'd0);
        #3 rst_n = 1'b1;
        net_done = 1'b1; net_y = 32'h77777777;
        tick();
        net_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk("r_no_result", 64'(res_valid), 64'd0);
            chk("r_no_batch_done", 64'(batch_done), 64'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/net_sequencer.md
NET_SEQUENCER -- requirements
Module: net_sequencer

Interface
REQ-001 Parameter I, default 2: input vector length in 32-bit IEEE-754 words.
REQ-002 Parameter O, default 1: output vector length in 32-bit words.
REQ-003 Parameter DEPTH, default 4: sample buffer entries, range 1..255.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles to wait for net_done per sample.
REQ-005 Port list SHALL be:
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- load_valid, in, 1: load_data is valid.
- load_data, in, 32*I: one input sample.
- load_ready, out, 1: sequencer accepts a sample this cycle.
- go, in, 1: single-cycle request to run the loaded batch.
- net_start, out, 1: one-cycle start pulse to the network.
- net_x, out, 32*I: sample presented to the network.
- net_y, in, 32*O: network result.
- net_done, in, 1: network completion; level, possibly held high.
- res_valid, out, 1: res_data is valid.
- res_data, out, 32*O: captured result.
- res_ready, in, 1: consumer accepts res_data.
- busy, out, 1: batch in progress.
- batch_done, out, 1: one-cycle pulse at batch end.
- err, out, 1: sticky timeout flag.
- count, out, 8: samples currently buffered.

Function
REQ-006 FSM states SHALL be IDLE, LAUNCH, WAIT, EMIT.
REQ-007 IDLE: load_ready = (count < DEPTH).
- A transfer occurs on load_valid & load_ready: buffer[wr_ptr] <= load_data, wr_ptr++, count++.
REQ-008 Outside IDLE, load_ready SHALL be 0 and load_valid SHALL be ignored.
REQ-009 IDLE with go=1 and count>0: next state LAUNCH, busy <= 1, rd_ptr <= 0, err cleared.
- go with count==0, or go outside IDLE, SHALL be ignored.
REQ-010 go and a load transfer in the same IDLE cycle: the load completes first, and the batch includes that sample.
REQ-011 LAUNCH (exactly one cycle): net_start=1, net_x=buffer[rd_ptr], timer <= 0; next state WAIT.
REQ-012 net_x SHALL hold buffer[rd_ptr] from LAUNCH through the end of WAIT.
- net_x is 0 in IDLE.
REQ-013 A 1-cycle delayed copy done_q of net_done SHALL be kept.
- Completion is net_done & !done_q, sampled only in WAIT.
- A done level already high when WAIT is entered SHALL NOT count as completion.
REQ-014 WAIT on completion: res_data <= net_y, next state EMIT.
REQ-015 WAIT otherwise: timer++.
- When timer == TIMEOUT-1 without completion: err <= 1, buffer flushed (count, wr_ptr, rd_ptr <= 0), busy <= 0, batch_done pulses, next state IDLE.
REQ-016 EMIT: res_valid=1, with res_data held stable until res_ready.
- On res_ready: rd_ptr++.
- If rd_ptr+1 < count: next state LAUNCH.
- Else: count, wr_ptr, rd_ptr <= 0; busy <= 0; batch_done pulses for 1 cycle; next state IDLE.
REQ-017 Results SHALL be emitted in load order, one per sample; none dropped or duplicated.
REQ-018 Minimum per-sample latency is LAUNCH 1 cycle + network latency + 1 cycle from the completion edge to res_valid.
REQ-019 Arithmetic: pointers and count are modulo-free, with 0 <= count <= DEPTH.
- Buffer data passes through bit-exact; no float interpretation.

Reset
REQ-020 When rst_n=0, asynchronously: state IDLE; net_start, busy, batch_done, err, res_valid, count = 0; net_x and res_data = 0; pointers, timer and done_q = 0.
REQ-021 Reset asserted mid-batch SHALL abort immediately.
- No res_valid and no batch_done after release.
- Buffer contents are discarded (count=0).

Verification
REQ-022 Load {0x00000000,0x3F800000}, go; network returns 0x3F800000 after 20 cycles -> exactly one net_start pulse, res_data=0x3F800000, batch_done 1 cycle after res_ready, busy=0.
REQ-023 Load 4 samples (DEPTH=4) -> load_ready=0 at count=4, and a 5th load_valid is not accepted. Go -> 4 results in load order, then count=0.
REQ-024 Hold net_done high across LAUNCH of sample 2 -> no capture until net_done falls and rises again.
REQ-025 net_done never asserted, TIMEOUT=16 -> err=1 and batch_done exactly 16 cycles after entering WAIT, count=0, go then accepted.
REQ-026 res_ready held low 10 cycles in EMIT -> res_data stable, no new net_start until the accept.
REQ-027 rst_n pulsed low during WAIT -> all outputs 0 asynchronously, with no result afterward.
